rom_load_ctrl: RTL and testbench
================================

Name: rom_load_ctrl

Overview:
Sequences the ROM byte stream from the ROM source (test or SD loader) into the cartridge memory write port. It consumes the 64-byte header and captures its fields. Payload bytes are packed little-endian into 16-bit words, buffered in a small FIFO and written through a req/ack memory port. The block sits between the loader and the SDRAM/ROM arbiter and reports busy, done and fail to the top-level boot logic.

Parameters:
FIFO_DEPTH, 4, payload word buffer entries (power of 2, >=2)
AW, 22, memory word address width
BASE_ADDR, 0, word address of the first payload word

Ports:
wclk  in  1  clock
resetn  in  1  synchronous active-low reset
src_dout  in  8  source byte
src_valid  in  1  one-cycle strobe per byte; never asserted on consecutive cycles
src_loading  in  1  source still streaming
src_fail  in  1  source error
mem_req  out  1  write request, held until acked
mem_addr  out  AW  word address
mem_wdata  out  16  word; byte 2n in [7:0], byte 2n+1 in [15:8]
mem_ack  in  1  one-cycle acceptance pulse while mem_req=1
map_ctrl  out  8  header byte 0
rom_type  out  8  header byte 1
rom_size  out  24  header bytes 2..4, little-endian payload byte count; 0 disables the check
hdr_valid  out  1  header fields captured
busy  out  1  not in DONE or FAIL
done  out  1  level, load complete
fail  out  1  level, sticky until reset
err_code  out  2  0 none, 1 FIFO overflow, 2 truncated header or src_fail, 3 size mismatch

Behaviour:
Reset: resetn is synchronous, active-low, clock wclk. It is sampled at any time, including mid-transfer, and returns every register to its reset value in one cycle. Reset values:
- state=HEADER, mem_req=0, mem_addr=BASE_ADDR, mem_wdata=0
- map_ctrl=0, rom_type=0, rom_size=0, hdr_valid=0
- done=0, fail=0, err_code=0, busy=1
- FIFO empty, byte counter=0, odd-byte holding register cleared

HEADER state:
- Counts src_valid bytes 0..63 and latches bytes 0..4 into the header fields; bytes 5..63 are discarded.
- On byte 63, sets hdr_valid=1 and goes to PAYLOAD.
- If src_loading=0 and src_valid=0 before byte 63 -> FAIL, err=2.

PAYLOAD state:
- An even byte goes to the holding register.
- An odd byte forms a word that is pushed to the FIFO in the same cycle.
- 24-bit payload byte counter increments per byte and saturates at 2^24-1.
- Push while the FIFO is full -> FAIL, err=1; the word is dropped.
- src_loading=0 and src_valid=0 -> FLUSH. If the byte count is odd, the held byte is pushed with 0x00 in [15:8].

FLUSH state:
- Waits for FIFO empty and mem_req=0.
- Then, if rom_size!=0 and count!=rom_size -> FAIL, err=3; else -> DONE.

Any state:
- src_fail=1 -> FAIL, err=2, unless already DONE/FAIL.
- DONE and FAIL are terminal until reset. In FAIL, mem_req completes any word already presented and no further words are issued.

Memory port:
- When mem_req=0 and the FIFO is non-empty: pop, present data, assert mem_req the next cycle.
- mem_addr and mem_wdata are stable while mem_req=1.
- On mem_ack, mem_addr increments and wraps modulo 2^AW. If the FIFO is non-empty, mem_req stays 1 with the next word the following cycle (back-to-back); else mem_req drops.
- Latency: byte 2n+1 strobe -> mem_req high after 2 cycles when the FIFO was empty.
- A FIFO push and pop in the same cycle is legal and does not count as overflow when full.

Decomposition:
A rom_load_pkg package holds:
- the state enum (HEADER, PAYLOAD, FLUSH, DONE, FAIL)
- the err_code constants
- HDR_LEN=64 and the header field byte offsets

One sub-module, load_word_fifo: a synchronous FIFO, parameterized width/depth, with push/pop/full/empty.

Test Plan:
1. Header 0x21,0x02,0x00,0x01,0x00 followed by 256 payload bytes 0x00..0xFF, mem_ack 1 cycle after req -> map_ctrl=0x21, rom_type=0x02, rom_size=256; 128 writes at addr 0..127 with first wdata 0x0100 and last 0xFFFE; done=1, err=0.
2. rom_size=3 and 3 payload bytes 0xAA,0xBB,0xCC -> writes 0xBBAA@0 and 0x00CC@1, done=1.
3. mem_ack withheld for 40 cycles during a byte every 2 cycles, FIFO_DEPTH=4 -> fail=1, err=1 on the 5th queued word; mem_req completes its word after ack and none further.
4. src_loading drops after 30 header bytes -> fail=1, err=2, hdr_valid=0, no mem_req ever.
5. rom_size=512 but 510 payload bytes sent -> 255 writes, then fail=1, err=3.
6. resetn low for 1 cycle mid-payload with mem_req=1 -> next cycle mem_req=0, state HEADER, hdr_valid=0; a restarted stream loads correctly from BASE_ADDR.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared state, error and header layout definitions
// for the ROM load controller.
package rom_load_pkg;

   typedef enum logic [2:0] {
      ST_HEADER,
      ST_PAYLOAD,
      ST_FLUSH,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_OVF  = 2'd1;
   localparam logic [1:0] ERR_SRC  = 2'd2;
   localparam logic [1:0] ERR_SIZE = 2'd3;

   localparam int HDR_LEN = 64;
   localparam logic [5:0] HDR_LAST  = 6'(HDR_LEN - 1);
   localparam logic [5:0] OFS_MAP   = 6'd0;
   localparam logic [5:0] OFS_TYPE  = 6'd1;
   localparam logic [5:0] OFS_SIZE0 = 6'd2;
   localparam logic [5:0] OFS_SIZE1 = 6'd3;
   localparam logic [5:0] OFS_SIZE2 = 6'd4;

   function automatic logic [23:0] sat_inc(
      input logic [23:0] v
   );
      return (&v) ? v : v + 24'd1;
   endfunction

endpackage

// File: rtl/load_word_fifo.sv
// Small synchronous FIFO for packed payload words.
// A push while full is dropped unless a pop frees a slot.
module load_word_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         wclk,
   input  logic         resetn,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wptr;
   logic [PW:0]  rptr;
   logic         wr;
   logic         rd;

   assign rd    = pop && !empty;
   assign wr    = push && (!full || rd);
   assign empty = wptr == rptr;
   assign full  = (wptr[PW] != rptr[PW]) &&
                  (wptr[PW-1:0] == rptr[PW-1:0]);
   assign dout  = mem[rptr[PW-1:0]];

   always_ff @(posedge wclk) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr) wptr <= wptr + (PW+1)'(1);
         if (rd) rptr <= rptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge wclk) begin
      if (wr) mem[wptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/rom_load_ctrl.sv
// Header capture, little-endian word packing and
// req/ack write sequencing of the ROM byte stream.
module rom_load_ctrl
   import rom_load_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int AW         = 22,
   parameter int BASE_ADDR  = 0
) (
   input  logic          wclk,
   input  logic          resetn,
   input  logic [7:0]    src_dout,
   input  logic          src_valid,
   input  logic          src_loading,
   input  logic          src_fail,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic          mem_ack,
   output logic [7:0]    map_ctrl,
   output logic [7:0]    rom_type,
   output logic [23:0]   rom_size,
   output logic          hdr_valid,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [1:0]    err_code
);

   state_t      state;
   state_t      state_nx;
   logic [1:0]  err_nx;
   logic [5:0]  hdr_cnt;
   logic [7:0]  hold;
   logic        phase;
   logic [23:0] count;
   logic        live;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic        ovf;
   logic        ack_ok;
   logic        src_end;
   logic [15:0] push_data;
   logic [15:0] fifo_dout;

   assign live    = state != ST_DONE && state != ST_FAIL;
   assign src_end = !src_valid && !src_loading;
   assign ack_ok  = mem_req && mem_ack;
   assign pop     = live && !empty && (!mem_req || mem_ack);
   assign ovf     = push && full && !pop;
   assign done    = state == ST_DONE;
   assign fail    = state == ST_FAIL;
   assign busy    = live;

   // A trailing odd byte is flushed with a zero upper half.
   always_comb begin
      push      = 1'b0;
      push_data = {src_dout, hold};
      if (state == ST_PAYLOAD && !src_fail && phase) begin
         if (src_valid) begin
            push = 1'b1;
         end else if (!src_loading) begin
            push      = 1'b1;
            push_data = {8'h00, hold};
         end
      end
   end

   always_comb begin
      state_nx = state;
      err_nx   = err_code;
      if (live && src_fail) begin
         state_nx = ST_FAIL;
         err_nx   = ERR_SRC;
      end else begin
         unique case (state)
            ST_HEADER: begin
               if (src_end) begin
                  state_nx = ST_FAIL;
                  err_nx   = ERR_SRC;
               end else if (src_valid && hdr_cnt == HDR_LAST) begin
                  state_nx = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (ovf) begin
                  state_nx = ST_FAIL;
                  err_nx   = ERR_OVF;
               end else if (src_end) begin
                  state_nx = ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (empty && !mem_req) begin
                  if (rom_size != 24'd0 && count != rom_size) begin
                     state_nx = ST_FAIL;
                     err_nx   = ERR_SIZE;
                  end else begin
                     state_nx = ST_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge wclk) begin
      if (!resetn) begin
         state    <= ST_HEADER;
         err_code <= ERR_NONE;
      end else begin
         state    <= state_nx;
         err_code <= err_nx;
      end
   end

   always_ff @(posedge wclk) begin
      if (!resetn) begin
         hdr_cnt   <= '0;
         hdr_valid <= 1'b0;
         map_ctrl  <= '0;
         rom_type  <= '0;
         rom_size  <= '0;
      end else if (state == ST_HEADER && src_valid && !src_fail) begin
         hdr_cnt <= hdr_cnt + 6'd1;
         case (hdr_cnt)
            OFS_MAP:   map_ctrl       <= src_dout;
            OFS_TYPE:  rom_type       <= src_dout;
            OFS_SIZE0: rom_size[7:0]   <= src_dout;
            OFS_SIZE1: rom_size[15:8]  <= src_dout;
            OFS_SIZE2: rom_size[23:16] <= src_dout;
            default: ;
         endcase
         if (hdr_cnt == HDR_LAST) hdr_valid <= 1'b1;
      end
   end

   always_ff @(posedge wclk) begin
      if (!resetn) begin
         hold  <= '0;
         phase <= 1'b0;
         count <= '0;
      end else if (state == ST_PAYLOAD && src_valid && !src_fail) begin
         if (!phase) hold <= src_dout;
         phase <= !phase;
         count <= sat_inc(count);
      end
   end

   always_ff @(posedge wclk) begin
      if (!resetn) begin
         mem_req   <= 1'b0;
         mem_addr  <= AW'(BASE_ADDR);
         mem_wdata <= '0;
      end else begin
         if (pop) begin
            mem_req   <= 1'b1;
            mem_wdata <= fifo_dout;
         end else if (ack_ok) begin
            mem_req <= 1'b0;
         end
         if (ack_ok) mem_addr <= mem_addr + AW'(1);
      end
   end

   load_word_fifo #(
      .W     (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .wclk   (wclk),
      .resetn (resetn),
      .push   (push),
      .din    (push_data),
      .pop    (pop),
      .dout   (fifo_dout),
      .full   (full),
      .empty  (empty)
   );

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Randomized self-checking bench for rom_load_ctrl; expected
// writes come from a byte-list model of the packed payload.
module tb_rom_load_ctrl;

   localparam int AW    = 22;
   localparam int DEPTH = 4;

   typedef logic [7:0]  bq_t[$];
   typedef logic [15:0] wq_t[$];

   logic          wclk = 1'b0;
   logic          resetn = 1'b0;
   logic [7:0]    src_dout = '0;
   logic          src_valid = 1'b0;
   logic          src_loading = 1'b1;
   logic          src_fail = 1'b0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic          mem_ack = 1'b0;
   logic [7:0]    map_ctrl;
   logic [7:0]    rom_type;
   logic [23:0]   rom_size;
   logic          hdr_valid;
   logic          busy;
   logic          done;
   logic          fail;
   logic [1:0]    err_code;

   rom_load_ctrl #(
      .FIFO_DEPTH (DEPTH),
      .AW         (AW),
      .BASE_ADDR  (0)
   ) dut (
      .wclk        (wclk),
      .resetn      (resetn),
      .src_dout    (src_dout),
      .src_valid   (src_valid),
      .src_loading (src_loading),
      .src_fail    (src_fail),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .map_ctrl    (map_ctrl),
      .rom_type    (rom_type),
      .rom_size    (rom_size),
      .hdr_valid   (hdr_valid),
      .busy        (busy),
      .done        (done),
      .fail        (fail),
      .err_code    (err_code)
   );

   always #5 wclk = ~wclk;

   int n_chk = 0;
   int n_pass = 0;
   int ack_lat = 1;
   bit ack_en = 1'b1;
   bit req_seen = 1'b0;
   logic [AW-1:0] got_addr[$];
   logic [15:0]   got_data[$];

   // Memory side: acks each request after ack_lat idle cycles.
   initial begin : responder
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(negedge wclk);
         mem_ack = 1'b0;
         if (mem_req) req_seen = 1'b1;
         if (!resetn || !mem_req) begin
            wait_cnt = 0;
         end else if (ack_en) begin
            if (wait_cnt >= ack_lat) begin
               mem_ack = 1'b1;
               got_addr.push_back(mem_addr);
               got_data.push_back(mem_wdata);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   function automatic wq_t model_words(input bq_t p);
      wq_t w;
      for (int i = 0; i < p.size(); i += 2)
         w.push_back({(i + 1 < p.size()) ? p[i+1] : 8'h00, p[i]});
      return w;
   endfunction

   function automatic bq_t rand_bytes(input int n);
      bq_t p;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   task automatic do_reset();
      @(negedge wclk);
      src_valid = 1'b0;
      src_loading = 1'b1;
      src_fail = 1'b0;
      resetn = 1'b0;
      repeat (2) @(negedge wclk);
      resetn = 1'b1;
      ack_en = 1'b1;
      got_addr.delete();
      got_data.delete();
      req_seen = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge wclk);
      src_dout = b;
      src_valid = 1'b1;
      @(negedge wclk);
      src_valid = 1'b0;
      repeat (gap) @(negedge wclk);
   endtask

   task automatic send_header(input logic [7:0] mc,
                              input logic [7:0] rt,
                              input logic [23:0] sz,
                              input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         case (i)
            0: b = mc;
            1: b = rt;
            2: b = sz[7:0];
            3: b = sz[15:8];
            4: b = sz[23:16];
            default: ;
         endcase
         send_byte(b, 0);
      end
   endtask

   task automatic send_payload(input bq_t p, input int max_gap);
      foreach (p[i]) send_byte(p[i], int'($urandom_range(max_gap, 0)));
   endtask

   task automatic end_and_wait(input int max, output bit ok);
      @(negedge wclk);
      src_loading = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge wclk);
         if (done || fail) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if (mem_req !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0)
         $display("FAIL reset_mem req=%0b addr=%0h data=%0h want 0 0 0",
                  mem_req, mem_addr, mem_wdata);
      else n_pass++;
      n_chk++;
      if ({map_ctrl, rom_type, rom_size, hdr_valid} !== '0)
         $display("FAIL reset_hdr map=%0h type=%0h size=%0h hv=%0b want 0",
                  map_ctrl, rom_type, rom_size, hdr_valid);
      else n_pass++;
      n_chk++;
      if ({busy, done, fail, err_code} !== 5'b10000)
         $display("FAIL reset_status busy=%0b done=%0b fail=%0b err=%0d want 1 0 0 0",
                  busy, done, fail, err_code);
      else n_pass++;
   endtask

   task automatic test_basic();
      bq_t p;
      wq_t exp;
      int bad;
      bit ok;
      do_reset();
      ack_lat = 1;
      for (int i = 0; i < 256; i++) p.push_back(8'(i));
      send_header(8'h21, 8'h02, 24'd256, 64);
      send_payload(p, 0);
      end_and_wait(2000, ok);
      n_chk++;
      if (!ok) $display("FAIL basic_timeout done=%0b fail=%0b want end", done, fail);
      else n_pass++;
      n_chk++;
      if (map_ctrl !== 8'h21 || rom_type !== 8'h02 || rom_size !== 24'd256)
         $display("FAIL basic_hdr map=%0h type=%0h size=%0d want 21 02 256",
                  map_ctrl, rom_type, rom_size);
      else n_pass++;
      n_chk++;
      if (done !== 1'b1 || err_code !== 2'd0 || hdr_valid !== 1'b1)
         $display("FAIL basic_status done=%0b err=%0d hv=%0b want 1 0 1",
                  done, err_code, hdr_valid);
      else n_pass++;
      exp = model_words(p);
      bad = (got_data.size() != exp.size()) ? 1 : 0;
      if (bad == 0)
         foreach (exp[i])
            if (got_data[i] !== exp[i] || got_addr[i] !== AW'(i)) bad++;
      n_chk++;
      if (bad != 0)
         $display("FAIL basic_writes got %0d words (%0d bad) want %0d",
                  got_data.size(), bad, exp.size());
      else n_pass++;
      n_chk++;
      if (got_data.size() != 128 || got_data[0] !== 16'h0100 ||
          got_data[127] !== 16'hFFFE)
         $display("FAIL basic_ends n=%0d first=%0h last=%0h want 128 0100 fffe",
                  got_data.size(), got_data[0], got_data[got_data.size()-1]);
      else n_pass++;
   endtask

   task automatic test_odd();
      logic lat0;
      logic lat1;
      bit ok;
      do_reset();
      ack_lat = 1;
      send_header(8'h00, 8'h00, 24'd3, 64);
      send_byte(8'hAA, 0);
      @(negedge wclk);
      src_dout = 8'hBB;
      src_valid = 1'b1;
      @(posedge wclk);
      #1 lat0 = mem_req;
      @(negedge wclk);
      src_valid = 1'b0;
      @(posedge wclk);
      #1 lat1 = mem_req;
      send_byte(8'hCC, 0);
      end_and_wait(200, ok);
      n_chk++;
      if (lat0 !== 1'b0 || lat1 !== 1'b1)
         $display("FAIL odd_latency req=%0b,%0b want 0,1", lat0, lat1);
      else n_pass++;
      n_chk++;
      if (!ok || done !== 1'b1 || err_code !== 2'd0)
         $display("FAIL odd_status done=%0b err=%0d want 1 0", done, err_code);
      else n_pass++;
      n_chk++;
      if (got_data.size() != 2 || got_data[0] !== 16'hBBAA ||
          got_data[1] !== 16'h00CC || got_addr[0] !== '0 || got_addr[1] !== AW'(1))
         $display("FAIL odd_writes n=%0d d0=%0h d1=%0h want 2 bbaa@0 00cc@1",
                  got_data.size(), got_data[0], got_data[got_data.size()-1]);
      else n_pass++;
   endtask

   task automatic test_overflow();
      bq_t p;
      do_reset();
      ack_en = 1'b0;
      p = rand_bytes(12);
      send_header(8'h00, 8'h00, 24'd0, 64);
      for (int i = 0; i < 2 * (DEPTH + 1); i++) send_byte(p[i], 0);
      repeat (2) @(negedge wclk);
      n_chk++;
      if (fail !== 1'b0)
         $display("FAIL ovf_early fail=%0b want 0 with %0d words held", fail, DEPTH + 1);
      else n_pass++;
      send_byte(p[10], 0);
      send_byte(p[11], 0);
      n_chk++;
      if (fail !== 1'b1 || err_code !== 2'd1 || mem_req !== 1'b1)
         $display("FAIL ovf_hit fail=%0b err=%0d req=%0b want 1 1 1",
                  fail, err_code, mem_req);
      else n_pass++;
      repeat (30) @(negedge wclk);
      ack_en = 1'b1;
      repeat (5) @(negedge wclk);
      req_seen = 1'b0;
      repeat (20) @(negedge wclk);
      n_chk++;
      if (got_data.size() != 1 || got_data[0] !== {p[1], p[0]} || got_addr[0] !== '0)
         $display("FAIL ovf_drain n=%0d d0=%0h want 1 word %0h",
                  got_data.size(), got_data[0], {p[1], p[0]});
      else n_pass++;
      n_chk++;
      if (req_seen !== 1'b0 || fail !== 1'b1 || err_code !== 2'd1)
         $display("FAIL ovf_after req_seen=%0b fail=%0b err=%0d want 0 1 1",
                  req_seen, fail, err_code);
      else n_pass++;
   endtask

   task automatic test_trunc();
      do_reset();
      send_header(8'h55, 8'h66, 24'd9, 30);
      @(negedge wclk);
      src_loading = 1'b0;
      repeat (10) @(negedge wclk);
      n_chk++;
      if (fail !== 1'b1 || err_code !== 2'd2 || hdr_valid !== 1'b0 ||
          req_seen !== 1'b0 || busy !== 1'b0)
         $display("FAIL trunc fail=%0b err=%0d hv=%0b req=%0b busy=%0b want 1 2 0 0 0",
                  fail, err_code, hdr_valid, req_seen, busy);
      else n_pass++;
   endtask

   task automatic test_size();
      bq_t p;
      wq_t exp;
      int bad;
      bit ok;
      do_reset();
      ack_lat = $urandom_range(2, 0);
      p = rand_bytes(510);
      send_header(8'h00, 8'h00, 24'd512, 64);
      send_payload(p, 0);
      end_and_wait(500, ok);
      exp = model_words(p);
      bad = (got_data.size() != exp.size()) ? 1 : 0;
      if (bad == 0)
         foreach (exp[i])
            if (got_data[i] !== exp[i] || got_addr[i] !== AW'(i)) bad++;
      n_chk++;
      if (bad != 0)
         $display("FAIL size_writes got %0d words (%0d bad) want %0d",
                  got_data.size(), bad, exp.size());
      else n_pass++;
      n_chk++;
      if (!ok || fail !== 1'b1 || done !== 1'b0 || err_code !== 2'd3)
         $display("FAIL size_status fail=%0b done=%0b err=%0d want 1 0 3",
                  fail, done, err_code);
      else n_pass++;
   endtask

   task automatic test_src_fail();
      do_reset();
      ack_lat = 0;
      send_header(8'h00, 8'h00, 24'd0, 64);
      send_payload(rand_bytes(6), 0);
      @(negedge wclk);
      src_fail = 1'b1;
      @(negedge wclk);
      src_fail = 1'b0;
      repeat (5) @(negedge wclk);
      n_chk++;
      if (fail !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0)
         $display("FAIL srcfail fail=%0b err=%0d busy=%0b want 1 2 0",
                  fail, err_code, busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bq_t p;
      wq_t exp;
      int n;
      int bad;
      bit ok;
      do_reset();
      ack_lat = 4;
      send_header(8'h00, 8'h00, 24'd0, 64);
      send_payload(rand_bytes(20), 0);
      for (int i = 0; i < 50 && !mem_req; i++) @(negedge wclk);
      n_chk++;
      if (mem_req !== 1'b1) $display("FAIL mid_req_wait req=%0b want 1", mem_req);
      else n_pass++;
      resetn = 1'b0;
      @(negedge wclk);
      n_chk++;
      if (mem_req !== 1'b0 || hdr_valid !== 1'b0 || busy !== 1'b1 ||
          mem_addr !== '0 || fail !== 1'b0)
         $display("FAIL mid_reset req=%0b hv=%0b busy=%0b addr=%0h fail=%0b want 0 0 1 0 0",
                  mem_req, hdr_valid, busy, mem_addr, fail);
      else n_pass++;
      resetn = 1'b1;
      got_addr.delete();
      got_data.delete();
      ack_lat = $urandom_range(2, 0);
      n = $urandom_range(30, 5);
      p = rand_bytes(n);
      send_header(8'h00, 8'h00, 24'(n), 64);
      send_payload(p, 2);
      end_and_wait(300, ok);
      exp = model_words(p);
      bad = (got_data.size() != exp.size()) ? 1 : 0;
      if (bad == 0)
         foreach (exp[i])
            if (got_data[i] !== exp[i] || got_addr[i] !== AW'(i)) bad++;
      n_chk++;
      if (!ok || done !== 1'b1 || bad != 0)
         $display("FAIL mid_restart done=%0b words=%0d bad=%0d want 1 %0d 0",
                  done, got_data.size(), bad, exp.size());
      else n_pass++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         bq_t p;
         wq_t exp;
         int n;
         int mode;
         int bad;
         logic [23:0] sz;
         logic [7:0] mc;
         logic [7:0] rt;
         bit exp_fail;
         bit ok;
         do_reset();
         ack_lat = $urandom_range(2, 0);
         n = $urandom_range(40, 0);
         mode = $urandom_range(2, 0);
         sz = (mode == 0) ? 24'd0 : (mode == 1) ? 24'(n) : 24'(n + 1);
         mc = 8'($urandom);
         rt = 8'($urandom);
         exp_fail = (sz != 0) && (sz != 24'(n));
         p = rand_bytes(n);
         send_header(mc, rt, sz, 64);
         send_payload(p, 3);
         end_and_wait(300, ok);
         exp = model_words(p);
         bad = (got_data.size() != exp.size()) ? 1 : 0;
         if (bad == 0)
            foreach (exp[i])
               if (got_data[i] !== exp[i] || got_addr[i] !== AW'(i)) bad++;
         n_chk++;
         if (map_ctrl !== mc || rom_type !== rt || rom_size !== sz)
            $display("FAIL rand_hdr map=%0h type=%0h size=%0d want %0h %0h %0d",
                     map_ctrl, rom_type, rom_size, mc, rt, sz);
         else n_pass++;
         n_chk++;
         if (bad != 0)
            $display("FAIL rand_writes got %0d words (%0d bad) want %0d",
                     got_data.size(), bad, exp.size());
         else n_pass++;
         n_chk++;
         if (!ok || fail !== exp_fail || done !== !exp_fail ||
             err_code !== (exp_fail ? 2'd3 : 2'd0))
            $display("FAIL rand_status fail=%0b done=%0b err=%0d want fail=%0b",
                     fail, done, err_code, exp_fail);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_odd();
      test_overflow();
      test_trunc();
      test_size();
      test_src_fail();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
